// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  Module      : irq_ctrl_pkg
//  Description : Shared constants, state encoding and vector helper for the
//                Game Boy interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

   // Interrupt source bit positions; bit 0 has the highest priority.
   localparam int IRQ_VBLANK = 0;
   localparam int IRQ_STAT   = 1;
   localparam int IRQ_TIMER  = 2;
   localparam int IRQ_SERIAL = 3;
   localparam int IRQ_JOYPAD = 4;

   // Jump vector low byte = VEC_BASE + VEC_STRIDE * source index.
   localparam logic [7:0] VEC_BASE   = 8'h40;
   localparam int         VEC_STRIDE = 8;

   // CPU-visible register addresses.
   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   // Dispatch sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_PUSH_HI = 3'd2,
      ST_PUSH_LO = 3'd3,
      ST_VECTOR  = 3'd4
   } irq_state_t;

   // Vector low byte for a given source index.
   function automatic logic [7:0] irq_vec(input logic [2:0] idx);
      return VEC_BASE + (8'(VEC_STRIDE) * {5'd0, idx});
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Combinational lowest-set-bit encoder. Produces a valid flag
//                and the index of the highest-priority (lowest) request bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc #(
   parameter int NUM_SRC = 5
) (
   input  logic [NUM_SRC-1:0] i_req,
   output logic               o_valid,
   output logic [2:0]         o_index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_valid = 1'b0;
      o_index = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_index = 3'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module      : irq_ctrl
//  Description : Game Boy interrupt controller. Owns IF/IE, raises the
//                pending line to the CPU and sequences the 5 M-cycle
//                interrupt dispatch (arbitration, vector, IF acknowledge).
//  Config      : IRQ_DISPATCH_CANCEL_EN - arbitrate at the VECTOR point with
//                live IF/IE (dispatch can be cancelled to vector 0x00).
//                Undefined: source is latched when dispatch is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 5,
   parameter int TICKS_PER_M = 4,
   parameter int DISPATCH_M  = 5
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               ce,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               cpu_sel_if,
   input  logic               cpu_sel_ie,
   input  logic               cpu_wr,
   input  logic [7:0]         cpu_di,
   output logic [7:0]         cpu_do,
   output logic               irq_pending,
   input  logic               dispatch_start,
   output logic               dispatch_busy,
   output logic [7:0]         irq_vector,
   output logic               vector_valid
);

   // Tick positions within one dispatch (counter is 0 at acceptance).
   localparam logic [4:0] c_push_hi = 5'(2 * TICKS_PER_M);
   localparam logic [4:0] c_push_lo = 5'(3 * TICKS_PER_M);
   localparam logic [4:0] c_vector  = 5'((DISPATCH_M - 1) * TICKS_PER_M);
   localparam logic [4:0] c_last    = 5'(DISPATCH_M * TICKS_PER_M - 1);

   logic [NUM_SRC-1:0] r_if;
   logic [7:0]         r_ie;
   irq_state_t         r_state;
   logic [4:0]         r_cnt;
   logic [7:0]         r_irq_vector;
   logic               r_vector_valid;

   irq_state_t         w_state_nxt;
   logic [4:0]         w_cnt_nxt;
   logic [4:0]         w_cnt_inc;
   logic               w_accept;
   logic               w_enter_vec;
   logic [NUM_SRC-1:0] w_req;
   logic               w_enc_valid;
   logic [2:0]         w_enc_idx;
   logic               w_ack_valid;
   logic [2:0]         w_ack_idx;
   logic [NUM_SRC-1:0] w_ack_mask;
   logic [NUM_SRC-1:0] w_if_nxt;

   assign w_req = r_if & r_ie[NUM_SRC-1:0];

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC)
   ) u_prio_enc (
      .i_req   (w_req),
      .o_valid (w_enc_valid),
      .o_index (w_enc_idx)
   );

   // The encoder's valid flag is exactly the OR-reduce of enabled requests.
   assign irq_pending   = w_enc_valid;
   assign dispatch_busy = (r_state != ST_IDLE);
   assign irq_vector    = r_irq_vector;
   assign vector_valid  = r_vector_valid;

   // Register read mux; unused IF bits read as ones, nothing selected reads open bus.
   assign cpu_do = cpu_sel_if ? {{(8 - NUM_SRC){1'b1}}, r_if} :
                   cpu_sel_ie ? r_ie : 8'hFF;

`ifdef IRQ_DISPATCH_CANCEL_EN
   // Arbitrate on the live IF/IE at the VECTOR point; an emptied set cancels.
   assign w_ack_valid = w_enc_valid;
   assign w_ack_idx   = w_enc_idx;
`else
   logic [2:0] r_sel;

   // Latch the winning source when the dispatch is accepted.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_sel <= 3'd0;
      end else if (ce && w_accept) begin
         r_sel <= w_enc_idx;
      end
   end

   assign w_ack_valid = 1'b1;
   assign w_ack_idx   = r_sel;
`endif

   assign w_ack_mask = (w_enter_vec && w_ack_valid) ? (NUM_SRC'(1) << w_ack_idx) : '0;
   assign w_cnt_inc  = r_cnt + 5'd1;

   // Dispatch sequencer state register, advancing only on ce.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 5'd0;
      end else if (ce) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: M-cycle boundaries fall out of the tick counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_enter_vec = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dispatch_start && w_enc_valid) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = 5'd0;
               w_accept    = 1'b1;
            end
         end
         default: begin
            w_cnt_nxt = w_cnt_inc;
            if (r_cnt == c_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 5'd0;
            end else if (w_cnt_inc == c_vector) begin
               w_state_nxt = ST_VECTOR;
               w_enter_vec = 1'b1;
            end else if (w_cnt_inc == c_push_lo) begin
               w_state_nxt = ST_PUSH_LO;
            end else if (w_cnt_inc == c_push_hi) begin
               w_state_nxt = ST_PUSH_HI;
            end
         end
      endcase
   end

   // IF update order: CPU write, then acknowledge clear, then new requests win.
   always_comb begin
      w_if_nxt = r_if;
      if (cpu_wr && cpu_sel_if) begin
         w_if_nxt = cpu_di[NUM_SRC-1:0];
      end
      w_if_nxt = (w_if_nxt & ~w_ack_mask) | irq_src;
   end

   // IF and IE registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_if <= '0;
         r_ie <= 8'h00;
      end else if (ce) begin
         r_if <= w_if_nxt;
         if (cpu_wr && cpu_sel_ie) begin
            r_ie <= cpu_di;
         end
      end
   end

   // Vector output and its one-ce valid pulse on the first VECTOR tick.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_irq_vector   <= 8'h00;
         r_vector_valid <= 1'b0;
      end else if (ce) begin
         r_vector_valid <= w_enter_vec;
         if (w_enter_vec) begin
            r_irq_vector <= w_ack_valid ? irq_vec(w_ack_idx) : 8'h00;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a behavioural model.
//  Config      : honours IRQ_DISPATCH_CANCEL_EN to match the DUT build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

`ifdef IRQ_DISPATCH_CANCEL_EN
   localparam bit CANCEL = 1'b1;
`else
   localparam bit CANCEL = 1'b0;
`endif

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b0;
   logic [4:0] irq_src = 5'd0;
   logic       cpu_sel_if = 1'b0;
   logic       cpu_sel_ie = 1'b0;
   logic       cpu_wr = 1'b0;
   logic [7:0] cpu_di = 8'h00;
   logic [7:0] cpu_do;
   logic       irq_pending;
   logic       dispatch_start = 1'b0;
   logic       dispatch_busy;
   logic [7:0] irq_vector;
   logic       vector_valid;

   irq_ctrl #(
      .NUM_SRC     (5),
      .TICKS_PER_M (4),
      .DISPATCH_M  (5)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ce             (ce),
      .irq_src        (irq_src),
      .cpu_sel_if     (cpu_sel_if),
      .cpu_sel_ie     (cpu_sel_ie),
      .cpu_wr         (cpu_wr),
      .cpu_di         (cpu_di),
      .cpu_do         (cpu_do),
      .irq_pending    (irq_pending),
      .dispatch_start (dispatch_start),
      .dispatch_busy  (dispatch_busy),
      .irq_vector     (irq_vector),
      .vector_valid   (vector_valid)
   );

   always #5 clk_sys = ~clk_sys;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: IF/IE as plain values, a dispatch is "ticks since
   // acceptance"; tick 16 is the vector point, tick 19 is the last one.
   // ---------------------------------------------------------------------
   logic [4:0] m_if = 5'd0;
   logic [7:0] m_ie = 8'h00;
   logic [7:0] m_vec = 8'h00;
   bit         m_busy = 1'b0;
   bit         m_vv = 1'b0;
   bit         m_ok = 1'b0;
   int         m_phase = 0;
   int         m_sel = 0;

   function automatic int lowest(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk_sys) begin : model
      automatic logic [4:0] nif;
      automatic logic [7:0] nie;
      automatic logic [7:0] nvec;
      automatic bit         nbusy;
      automatic bit         nvv;
      automatic int         nphase;
      automatic int         nsel;
      automatic int         tgt;
      automatic int         ack;
      if (reset) begin
         m_if    <= 5'd0;
         m_ie    <= 8'h00;
         m_vec   <= 8'h00;
         m_busy  <= 1'b0;
         m_vv    <= 1'b0;
         m_phase <= 0;
         m_ok    <= 1'b1;
      end else if (ce) begin
         nif = m_if; nie = m_ie; nvec = m_vec; nbusy = m_busy;
         nphase = m_phase; nsel = m_sel; nvv = 1'b0; ack = -1;
         if (cpu_wr && cpu_sel_if) nif = cpu_di[4:0];
         if (cpu_wr && cpu_sel_ie) nie = cpu_di;
         if (m_busy) begin
            nphase = m_phase + 1;
            if (nphase == 16) begin
               nvv  = 1'b1;
               tgt  = CANCEL ? lowest(m_if & m_ie[4:0]) : m_sel;
               nvec = (tgt < 0) ? 8'h00 : 8'(64 + 8 * tgt);
               ack  = tgt;
            end
            if (m_phase == 19) nbusy = 1'b0;
         end else if (dispatch_start && ((m_if & m_ie[4:0]) != 5'd0)) begin
            nbusy  = 1'b1;
            nphase = 0;
            nsel   = lowest(m_if & m_ie[4:0]);
         end
         if (ack >= 0) nif[ack] = 1'b0;
         nif = nif | irq_src;
         m_if    <= nif;
         m_ie    <= nie;
         m_vec   <= nvec;
         m_busy  <= nbusy;
         m_vv    <= nvv;
         m_phase <= nphase;
         m_sel   <= nsel;
      end
   end

   // Compare DUT against the model on every falling edge once reset has been seen.
   always @(negedge clk_sys) begin
      if (m_ok) begin
         check("busy", {7'd0, dispatch_busy}, {7'd0, m_busy});
         check("vector_valid", {7'd0, vector_valid}, {7'd0, m_vv});
         check("irq_vector", irq_vector, m_vec);
         check("irq_pending", {7'd0, irq_pending}, {7'd0, ((m_if & m_ie[4:0]) != 5'd0)});
         if (cpu_sel_if) check("cpu_do_if", cpu_do, {3'b111, m_if});
         else if (cpu_sel_ie) check("cpu_do_ie", cpu_do, m_ie);
      end
   end

   // ---------------------------------------------------------------------
   // Directed stimulus helpers: one ce tick = one ce=1 cycle + one ce=0 cycle.
   // ---------------------------------------------------------------------
   task automatic drive(input logic [4:0] src, input bit wr, input bit sif, input bit sie,
                        input logic [7:0] di, input bit st);
      ce = 1'b1; irq_src = src; cpu_wr = wr; cpu_sel_if = sif; cpu_sel_ie = sie;
      cpu_di = di; dispatch_start = st;
      @(posedge clk_sys); #2;
      ce = 1'b0; irq_src = 5'd0; cpu_wr = 1'b0; cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
      dispatch_start = 1'b0;
      @(posedge clk_sys); #2;
   endtask

   task automatic tick_idle();             drive(5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
   task automatic tick_src(input logic [4:0] s); drive(s, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); endtask
   task automatic tick_start();            drive(5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1); endtask
   task automatic wr_if(input logic [7:0] v); drive(5'd0, 1'b1, 1'b1, 1'b0, v, 1'b0); endtask
   task automatic wr_ie(input logic [7:0] v); drive(5'd0, 1'b1, 1'b0, 1'b1, v, 1'b0); endtask

   task automatic rd(input bit sel_if, output logic [7:0] v);
      cpu_sel_if = sel_if; cpu_sel_ie = !sel_if;
      #1 v = cpu_do;
      cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
   endtask

   // Full dispatch; optional IE write on step ie_step (0 = none).
   task automatic run_dispatch(input int ie_step, input logic [7:0] ie_val,
                               output bit vv15, output bit vv16, output logic [7:0] vec16,
                               output logic [7:0] if16, output bit busy_end);
      vv15 = 1'b0; vv16 = 1'b0; vec16 = 8'h00; if16 = 8'h00;
      tick_start();
      for (int j = 1; j <= 20; j++) begin
         if (j == ie_step) wr_ie(ie_val);
         else tick_idle();
         if (j == 15) vv15 = vector_valid;
         if (j == 16) begin
            vv16  = vector_valid;
            vec16 = irq_vector;
            rd(1'b1, if16);
         end
      end
      busy_end = dispatch_busy;
   endtask

   initial begin : stim
      logic [7:0] v;
      logic [7:0] vec;
      logic [7:0] ifv;
      bit         vv15;
      bit         vv16;
      bit         be;
      bit         vv_seen;
      int         r;

      repeat (3) @(posedge clk_sys);
      #2 reset = 1'b0;

      // Reset state
      rd(1'b1, v); check("reset IF", v, 8'hE0);
      rd(1'b0, v); check("reset IE", v, 8'h00);
      check("reset busy", {7'd0, dispatch_busy}, 8'h00);
      check("reset vv", {7'd0, vector_valid}, 8'h00);
      check("reset vector", irq_vector, 8'h00);
      check("reset pending", {7'd0, irq_pending}, 8'h00);

      // Timer request and dispatch
      wr_ie(8'h04);
      tick_src(5'h04);
      rd(1'b1, v); check("timer IF", v, 8'hE4);
      check("timer pending", {7'd0, irq_pending}, 8'h01);
      run_dispatch(0, 8'h00, vv15, vv16, vec, ifv, be);
      check("timer vv before 16", {7'd0, vv15}, 8'h00);
      check("timer vv at 16", {7'd0, vv16}, 8'h01);
      check("timer vector", vec, 8'h50);
      check("timer IF after ack", ifv, 8'hE0);
      check("timer busy end", {7'd0, be}, 8'h00);

      // All sources pending: priority order
      wr_if(8'h1F);
      wr_ie(8'h1F);
      run_dispatch(0, 8'h00, vv15, vv16, vec, ifv, be);
      check("prio1 vector", vec, 8'h40);
      check("prio1 IF", ifv, 8'hFE);
      run_dispatch(0, 8'h00, vv15, vv16, vec, ifv, be);
      check("prio2 vector", vec, 8'h48);
      check("prio2 IF", ifv, 8'hFC);
      check("prio2 vv", {7'd0, vv16}, 8'h01);

      // Write IF=0 colliding with a timer pulse
      drive(5'h04, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      rd(1'b1, v); check("write vs pulse IF", v, 8'hE4);

      // IE cleared during PUSH_HI
      wr_ie(8'h04);
      run_dispatch(9, 8'h00, vv15, vv16, vec, ifv, be);
      check("cancel vv", {7'd0, vv16}, 8'h01);
      check("cancel vector", vec, CANCEL ? 8'h00 : 8'h50);
      check("cancel IF", ifv, CANCEL ? 8'hE4 : 8'hE0);
      rd(1'b0, v); check("cancel IE", v, 8'h00);

      // Reset at tick 10 of a dispatch
      wr_if(8'h04);
      wr_ie(8'h04);
      tick_start();
      repeat (10) tick_idle();
      check("pre-reset busy", {7'd0, dispatch_busy}, 8'h01);
      reset = 1'b1;
      @(posedge clk_sys); #2;
      reset = 1'b0;
      check("mid reset busy", {7'd0, dispatch_busy}, 8'h00);
      vv_seen = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick_idle();
         if (vector_valid) vv_seen = 1'b1;
      end
      check("mid reset no vv", {7'd0, vv_seen}, 8'h00);
      rd(1'b1, v); check("mid reset IF", v, 8'hE0);
      rd(1'b0, v); check("mid reset IE", v, 8'h00);

      // dispatch_start without an enabled request is ignored
      wr_if(8'h01);
      tick_start();
      check("ignored start busy", {7'd0, dispatch_busy}, 8'h00);
      tick_idle();
      check("ignored start busy2", {7'd0, dispatch_busy}, 8'h00);

      // Randomized traffic, checked by the model every cycle
      for (int k = 0; k < 5000; k++) begin
         @(posedge clk_sys); #2;
         ce = ($urandom_range(0, 1) == 1);
         irq_src = ($urandom_range(0, 5) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
         r = $urandom_range(0, 15);
         cpu_wr = (r < 2);
         cpu_sel_if = (r == 0) || (r == 2);
         cpu_sel_ie = (r == 1) || (r == 3);
         cpu_di = 8'($urandom);
         dispatch_start = ($urandom_range(0, 5) == 0);
         reset = ($urandom_range(0, 799) == 0);
      end
      @(posedge clk_sys); #2;
      ce = 1'b0; irq_src = 5'd0; cpu_wr = 1'b0; cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
      dispatch_start = 1'b0; reset = 1'b0;
      repeat (4) @(posedge clk_sys);
      #2;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Game Boy interrupt controller. Owns IF (0xFF0F) and IE (0xFFFF).
- Collects request pulses from the timer, PPU (VBlank and STAT), serial and joypad.
- Raises a wake/request line to the CPU.
- Sequences the 5 M-cycle interrupt dispatch: vector selection, priority arbitration and IF-bit acknowledge, timed on the CPU clock enable.

Parameters:
NUM_SRC, 5, number of interrupt sources; bit 0 has the highest priority.
TICKS_PER_M, 4, ce ticks per M-cycle.
DISPATCH_M, 5, M-cycles in one dispatch sequence.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  CPU clock enable (4/8 MiHz)
irq_src  in  NUM_SRC  request pulses, 1 clk_sys wide, sampled when ce=1: [0]VBlank [1]STAT [2]Timer [3]Serial [4]Joypad
cpu_sel_if  in  1  register select, IF
cpu_sel_ie  in  1  register select, IE
cpu_wr  in  1  write strobe
cpu_di  in  8  write data
cpu_do  out  8  read data for the selected register
irq_pending  out  1  OR-reduce of (IF & IE); used for HALT wake and the IME check; combinational
dispatch_start  in  1  CPU commits to dispatch (IME=1, irq_pending=1); sampled on ce
dispatch_busy  out  1  dispatch sequence active
irq_vector  out  8  jump vector low byte; high byte is always 0x00
vector_valid  out  1  one-ce pulse, final M-cycle of dispatch

Behaviour:
- Reset values:
  - if_r=0, ie_r=0
  - state=IDLE, tick counter=0
  - irq_vector=0x00, vector_valid=0, dispatch_busy=0
- Reads:
  - IF reads {3'b111, if_r[4:0]}.
  - IE reads all 8 bits of ie_r; bits 7:5 are stored and returned.
- IF update on each ce, in priority order (later items override earlier):
  1. CPU write: if_r <= cpu_di[4:0].
  2. Dispatch acknowledge clears the selected bit.
  3. irq_src bits are ORed in. A set coinciding with a write or acknowledge on the same bit wins.
- IE write takes effect on the ce it is sampled.
- irq_pending = |(if_r & ie_r[4:0]). Zero latency from the register state.
- State machine (advances only on ce; 5-bit tick counter):
  - IDLE: on dispatch_start and irq_pending, go to WAIT, counter=0, dispatch_busy=1. dispatch_start with irq_pending=0 is ignored.
  - WAIT: M-cycles 0-1 (internal cycles).
  - PUSH_HI: M-cycle 2 (CPU pushes PCh).
  - PUSH_LO: M-cycle 3 (CPU pushes PCl).
  - VECTOR: M-cycle 4. On its first tick:
    - resolve sel = lowest set bit of (if_r & ie_r[4:0]);
    - irq_vector = 0x40 + 8*sel;
    - clear if_r[sel];
    - pulse vector_valid for one ce.
    - On its last tick: return to IDLE, dispatch_busy=0.
- Back-to-back dispatch: dispatch_start is accepted on the first ce after returning to IDLE.
- Reset mid-dispatch: immediate IDLE. No IF bit is cleared and no vector_valid pulse is issued.
- Source pulses during dispatch still set IF; only the arbitration point below decides which bit is acknowledged.

Optional Feature:
- Macro: IRQ_DISPATCH_CANCEL_EN.
- Defined (hardware-accurate): arbitration runs at the VECTOR point using the IF/IE values current at that moment.
  - A pending set emptied during PUSH_HI/PUSH_LO (e.g. the IE write performed by the PCh push to 0xFFFF) gives irq_vector=0x00, no IF bit cleared, and vector_valid still pulsed.
- Undefined: sel is latched when dispatch_start is accepted.
  - VECTOR uses the latched sel unconditionally and always clears that bit, even if IE changed meanwhile.

Decomposition:
- Shared package holds:
  - source index constants IRQ_VBLANK=0, IRQ_STAT=1, IRQ_TIMER=2, IRQ_SERIAL=3, IRQ_JOYPAD=4;
  - vector base 8'h40 and stride 8;
  - state encoding (IDLE, WAIT, PUSH_HI, PUSH_LO, VECTOR);
  - register addresses 0xFF0F and 0xFFFF.
- One sub-module, irq_prio_enc: a combinational lowest-set-bit encoder producing a NUM_SRC-wide request to {valid, index[2:0]}. It is reused by both build variants.

Test Plan:
- Timer pulse with IE=0x04 → IF reads 0xE4, irq_pending=1. Dispatch → vector_valid at tick 16 after start, irq_vector=0x50, IF reads 0xE0.
- IF=0x1F, IE=0x1F, dispatch → irq_vector=0x40, IF=0x1E. A second dispatch → 0x48, IF=0x1C.
- CPU writes IF=0x00 on the same ce as a timer pulse → IF reads 0xE4.
- IF=0x04, IE=0x04, IE written to 0x00 during PUSH_HI:
  - with IRQ_DISPATCH_CANCEL_EN: irq_vector=0x00, IF stays 0xE4;
  - without it: irq_vector=0x50, IF becomes 0xE0.
- Reset asserted at tick 10 of a dispatch → dispatch_busy=0 next cycle, no vector_valid, IF=0xE0 and IE=0x00 after reset.
- dispatch_start with IF=0x01, IE=0x00 → state stays IDLE, dispatch_busy remains 0.
